// File: rtl/spi_pkg.sv
// Shared SPI definitions: command codes, frame geometry and master state encoding.
// The slave side uses the same command constants.
package spi_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_WR_ADDR = 2'b00;
  localparam cmd_t CMD_WR_DATA = 2'b01;
  localparam cmd_t CMD_RD_ADDR = 2'b10;
  localparam cmd_t CMD_RD_DATA = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RECV  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  function automatic logic [FRAME_W-1:0] make_frame(input cmd_t c, input logic [DATA_W-1:0] d);
    return {c, d};
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for spi_master: 10-bit load/shift-out register and 8-bit shift-in register.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [FRAME_W-1:0]  frame_in,
  input  logic                shift_en,
  output logic                tx_msb,
  input  logic                capture_en,
  input  logic                miso,
  output logic [DATA_W-1:0]   rx_next
);

  logic [FRAME_W-1:0] tx_reg;
  logic [DATA_W-1:0]  rx_reg;

  assign tx_msb  = tx_reg[FRAME_W-1];
  assign rx_next = {rx_reg[DATA_W-2:0], miso};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_reg <= '0;
      rx_reg <= '0;
    end else begin
      if (load)
        tx_reg <= frame_in;
      else if (shift_en)
        tx_reg <= {tx_reg[FRAME_W-2:0], 1'b0};
      if (capture_en)
        rx_reg <= rx_next;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: sends one {cmd, din} frame per start on MOSI under SS_n and, for
// read-data commands, captures the 8-bit reply from MISO after RD_WAIT turnaround cycles.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] WAIT_LAST = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [3:0]        cnt;
  logic              is_rd;
  logic              accept;
  logic              shift_en;
  logic              capture_en;
  logic              tx_msb;
  logic [DATA_W-1:0] rx_next;

  assign accept     = (state == ST_IDLE) && start;
  // START already drives bit 9 out, so SHIFT only needs to advance for bits 8..0.
  assign shift_en   = (state == ST_START) || ((state == ST_SHIFT) && (cnt != 4'd9));
  assign capture_en = (state == ST_RECV);

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .frame_in   (make_frame(cmd, din)),
    .shift_en   (shift_en),
    .tx_msb     (tx_msb),
    .capture_en (capture_en),
    .miso       (MISO),
    .rx_next    (rx_next)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_START;
      ST_START: next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt == 4'd9) begin
          if (!is_rd)            next_state = ST_STOP;
          else if (RD_WAIT == 0) next_state = ST_RECV;
          else                   next_state = ST_WAIT;
        end
      end
      ST_WAIT:  if (cnt == WAIT_LAST) next_state = ST_RECV;
      ST_RECV:  if (cnt == 4'd7) next_state = ST_STOP;
      ST_STOP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      is_rd    <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= next_state;
      cnt      <= (next_state != state) ? 4'd0 : cnt + 4'd1;
      SS_n     <= (next_state == ST_IDLE) || (next_state == ST_STOP);
      MOSI     <= shift_en ? tx_msb : 1'b0;
      busy     <= (next_state != ST_IDLE);
      done     <= (next_state == ST_STOP);
      rd_valid <= (next_state == ST_STOP) && (state == ST_RECV);
      if (accept)
        is_rd <= (cmd == CMD_RD_DATA);
      if ((state == ST_RECV) && (cnt == 4'd7))
        rd_data <= rx_next;
    end
  end

endmodule
